// File: rtl/sram_like_arbiter_pkg.sv
// Shared IDs, SRAM size codes and the request-field bundle for the IF/MEM SRAM-like arbiter.
package sram_like_arbiter_pkg;

  localparam logic ARB_ID_INST = 1'b0;
  localparam logic ARB_ID_DATA = 1'b1;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } sram_cmd_t;

endpackage

// File: rtl/sram_arb_id_fifo.sv
// 1-bit sync FIFO of outstanding requester IDs; dout is the head, valid when !empty.
// Push into a full FIFO or pop from an empty one is ignored; push+pop together is legal at any count.
module sram_arb_id_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic dout,
  output logic full,
  output logic empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic          mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Power-of-2 depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// 2:1 IF/MEM arbiter onto one SRAM-like master; zero-latency request path, in-order data_ok routing via an ID FIFO.
// Grant is held while the master stalls a request; m_req drops while OUTST_DEPTH are outstanding. ARB_RR_EN selects round-robin.
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int OUTST_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [3:0]  m_wstrb,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata
);

  sram_cmd_t inst_cmd;
  sram_cmd_t data_cmd;
  sram_cmd_t sel_cmd;
  logic      grant;
  logic      grant_r;
  logic      lock;
  logic      granted_req;
  logic      handshake;
  logic      pop;
  logic      fifo_full;
  logic      fifo_empty;
  logic      fifo_head;

`ifdef ARB_RR_EN
  logic rr_last;
`endif

  assign inst_cmd = {inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata};
  assign data_cmd = {data_wr, data_size, data_wstrb, data_addr, data_wdata};

  always_comb begin
    grant = ARB_ID_INST;
    if (lock) grant = grant_r;
`ifdef ARB_RR_EN
    else if (inst_req && data_req) grant = ~rr_last;
`endif
    else if (data_req) grant = ARB_ID_DATA;
  end

  // Outputs are forced quiet during reset so nothing leaks to the bridge being reset alongside us.
  assign granted_req = (grant == ARB_ID_DATA) ? data_req : inst_req;
  assign m_req       = granted_req && !fifo_full && !reset;
  assign sel_cmd     = reset ? '0 : ((grant == ARB_ID_DATA) ? data_cmd : inst_cmd);
  assign m_wr        = sel_cmd.wr;
  assign m_size      = sel_cmd.size;
  assign m_wstrb     = sel_cmd.wstrb;
  assign m_addr      = sel_cmd.addr;
  assign m_wdata     = sel_cmd.wdata;

  assign handshake    = m_req && m_addr_ok;
  assign inst_addr_ok = handshake && (grant == ARB_ID_INST);
  assign data_addr_ok = handshake && (grant == ARB_ID_DATA);

  assign pop          = m_data_ok && !fifo_empty && !reset;
  assign inst_data_ok = pop && (fifo_head == ARB_ID_INST);
  assign data_data_ok = pop && (fifo_head == ARB_ID_DATA);
  assign inst_rdata   = reset ? '0 : m_rdata;
  assign data_rdata   = reset ? '0 : m_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      lock    <= 1'b0;
      grant_r <= ARB_ID_INST;
    end else if (m_req && !m_addr_ok) begin
      lock    <= 1'b1;
      grant_r <= grant;
    end else if (m_addr_ok) begin
      lock    <= 1'b0;
    end
  end

`ifdef ARB_RR_EN
  always_ff @(posedge clk) begin
    if (reset)          rr_last <= ARB_ID_INST;
    else if (handshake) rr_last <= grant;
  end
`endif

  sram_arb_id_fifo #(
    .DEPTH (OUTST_DEPTH)
  ) u_id_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (handshake),
    .pop   (pop),
    .din   (grant),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed + random stimulus for sram_like_arbiter, checked each cycle against a queue-based reference model.
module tb_sram_like_arbiter;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size, m_size;
  logic [3:0]  inst_wstrb, data_wstrb, m_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        m_req, m_wr, m_addr_ok, m_data_ok;
  logic [31:0] m_addr, m_wdata, m_rdata;

  int checks = 0;
  int errors = 0;

  // Reference state: outstanding IDs in acceptance order, the side owning a stalled request, last accepted side.
  bit mq[$];
  bit own_v, own, rr_l;
  bit got_i, got_d;

  always #5 clk = ~clk;

  sram_like_arbiter #(.OUTST_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb),
    .m_addr(m_addr), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    bit g, full, hs, pop, head, emreq;
    logic [31:0] ea, ew, ectl;
    @(negedge clk);
    full = (mq.size() == DEPTH);
    head = (mq.size() > 0) ? mq[0] : 1'b0;
    if (own_v) g = own;
`ifdef ARB_RR_EN
    else if (inst_req && data_req) g = !rr_l;
`endif
    else g = data_req;
    emreq = !reset && !full && (g ? data_req : inst_req);
    hs    = emreq && m_addr_ok;
    pop   = !reset && m_data_ok && (mq.size() > 0);
    ea    = reset ? 32'h0 : (g ? data_addr : inst_addr);
    ew    = reset ? 32'h0 : (g ? data_wdata : inst_wdata);
    ectl  = reset ? 32'h0 : (g ? {25'h0, data_wr, data_size, data_wstrb} : {25'h0, inst_wr, inst_size, inst_wstrb});
    chk("m_req", {31'h0, m_req}, {31'h0, emreq});
    chk("m_addr", m_addr, ea);
    chk("m_wdata", m_wdata, ew);
    chk("m_ctl", {25'h0, m_wr, m_size, m_wstrb}, ectl);
    chk("inst_addr_ok", {31'h0, inst_addr_ok}, {31'h0, hs && !g});
    chk("data_addr_ok", {31'h0, data_addr_ok}, {31'h0, hs && g});
    chk("inst_data_ok", {31'h0, inst_data_ok}, {31'h0, pop && !head});
    chk("data_data_ok", {31'h0, data_data_ok}, {31'h0, pop && head});
    chk("inst_rdata", inst_rdata, reset ? 32'h0 : m_rdata);
    chk("data_rdata", data_rdata, reset ? 32'h0 : m_rdata);
    got_i = hs && !g;
    got_d = hs && g;
    if (reset) begin
      mq.delete();
      own_v = 1'b0;
      rr_l  = 1'b0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (hs) begin
        mq.push_back(g);
        rr_l = g;
      end
      if (emreq && !m_addr_ok) begin
        own_v = 1'b1;
        own   = g;
      end else if (m_addr_ok) begin
        own_v = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit ir, input bit dr, input bit aok, input bit dok, input logic [31:0] rd);
    inst_req  = ir;
    data_req  = dr;
    m_addr_ok = aok;
    m_data_ok = dok;
    m_rdata   = rd;
    cycle();
  endtask

  initial begin
    reset = 1'b1;
    inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_wstrb = 4'hf; inst_addr = 32'hbfc00000; inst_wdata = 32'h0;
    data_req = 0; data_wr = 1; data_size = 2'd2; data_wstrb = 4'hf; data_addr = 32'h80001000; data_wdata = 32'h11223344;
    m_addr_ok = 0; m_data_ok = 0; m_rdata = 32'h0;
    @(posedge clk); #1;
    drive(1, 1, 1, 1, 32'hdeadbeef);   // outputs must stay 0 during reset
    drive(0, 0, 0, 0, 0);
    reset = 1'b0;

    // Single inst fetch, data returned later.
    drive(1, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 32'h24080001);

    // Both request together.
    drive(1, 1, 1, 0, 0);
    drive(1, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 32'haaaa0001);
    drive(0, 0, 0, 1, 32'hbbbb0002);

    // Stalled inst request keeps the grant while data waits.
    inst_addr = 32'hbfc00010;
    drive(1, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    drive(1, 1, 1, 0, 0);
    drive(0, 1, 1, 0, 0);
    drive(0, 0, 0, 1, 32'h1);
    drive(0, 0, 0, 1, 32'h2);

    // Fill the ID FIFO, then release one slot.
    data_wr = 0;
    for (int i = 0; i < 5; i++) drive(0, 1, 1, 0, 0);
    drive(0, 1, 1, 1, 32'h3);
    drive(0, 1, 1, 0, 0);
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 1, 32'h10 + i);

    // Push and pop together at count 2, then data_ok on empty FIFO.
    drive(1, 0, 1, 0, 0);
    drive(0, 1, 1, 0, 0);
    drive(1, 0, 1, 1, 32'h20);
    drive(0, 0, 0, 1, 32'h21);
    drive(0, 0, 0, 1, 32'h22);
    drive(0, 0, 0, 1, 32'h23);
    drive(0, 0, 0, 1, 32'h24);

    // Continuous contention, then reset with transactions outstanding.
    for (int i = 0; i < 8; i++) drive(1, 1, 1, 1, 32'h30 + i);
    drive(1, 1, 1, 0, 0);
    drive(1, 1, 0, 0, 0);
    reset = 1'b1;
    drive(1, 1, 1, 1, 32'h40);
    drive(1, 1, 0, 1, 32'h41);
    reset = 1'b0;
    drive(1, 1, 0, 1, 32'h42);
    drive(1, 1, 1, 0, 0);
    drive(0, 0, 0, 1, 32'h43);

    // Random traffic: each requester holds its request until accepted.
    got_i = 1'b1;
    got_d = 1'b1;
    inst_req = 0;
    data_req = 0;
    for (int n = 0; n < 400; n++) begin
      if (!inst_req || got_i) begin
        inst_req   = $urandom_range(0, 1);
        inst_wr    = 1'b0;
        inst_size  = 2'd2;
        inst_wstrb = $urandom_range(0, 15);
        inst_addr  = $urandom;
        inst_wdata = $urandom;
      end
      if (!data_req || got_d) begin
        data_req   = $urandom_range(0, 1);
        data_wr    = $urandom_range(0, 1);
        data_size  = $urandom_range(0, 2);
        data_wstrb = $urandom_range(0, 15);
        data_addr  = $urandom;
        data_wdata = $urandom;
      end
      m_addr_ok = ($urandom_range(0, 3) != 0);
      m_data_ok = ($urandom_range(0, 2) == 0);
      m_rdata   = $urandom;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
